// File: rtl/pipes_pkg.sv
// Shared pipeline types: the fetch-to-decode payload, the fetch FSM states and the reset PC.
package pipes_pkg;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] PC_STEP  = 64'd4;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        en;
  } fetch_data_t;

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues instruction-bus requests and registers each returned word
// for decode, absorbing decode stalls and execute redirects (also mid-request).
//
// Bus handshake: ireq_valid/ireq_addr form a request that, once raised, holds a stable
// address until iresp_data_ok completes it; a request is never withdrawn.
module fetch_stage
  import pipes_pkg::*;
#(
  parameter logic [63:0] RESET_PC_P = RESET_PC
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              ireq_valid,
  output logic [63:0]       ireq_addr,
  input  logic              iresp_data_ok,
  input  logic [31:0]       iresp_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  output fetch_data_t       dataF,
  output logic [1:0]        state_dbg
);

  fetch_state_t state, state_n;
  logic [63:0]  pc, pc_n;
  logic [63:0]  pend_pc, pend_pc_n;
  logic [31:0]  ibuf, ibuf_n;
  fetch_data_t  data_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= FETCH;
      pc      <= RESET_PC_P;
      pend_pc <= '0;
      ibuf    <= '0;
      dataF   <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_pc_n;
      ibuf    <= ibuf_n;
      dataF   <= data_n;
    end
  end

  // The request is gated by reset so the bus sees nothing while resetn is low.
  assign ireq_valid = resetn && (state != HOLD);
  assign ireq_addr  = pc;
  assign state_dbg  = state;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_pc_n = pend_pc;
    ibuf_n    = ibuf;
    data_n    = dataF;
    unique case (state)
      FETCH: begin
        if (iresp_data_ok) begin
          if (redirect_valid) begin
            pc_n      = redirect_pc;
            data_n.en = 1'b0;
          end else if (!stall) begin
            data_n    = '{raw_instr: iresp_data, pc: pc, en: 1'b1};
            pc_n      = pc + PC_STEP;
          end else begin
            ibuf_n    = iresp_data;
            state_n   = HOLD;
          end
        end else if (redirect_valid) begin
          // Address must stay on the bus until the stale response arrives.
          pend_pc_n = redirect_pc;
          data_n.en = 1'b0;
          state_n   = DISCARD;
        end else if (!stall) begin
          data_n.en = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n      = redirect_pc;
          data_n.en = 1'b0;
          state_n   = FETCH;
        end else if (!stall) begin
          data_n    = '{raw_instr: ibuf, pc: pc, en: 1'b1};
          pc_n      = pc + PC_STEP;
          state_n   = FETCH;
        end
      end
      DISCARD: begin
        data_n.en = 1'b0;
        if (iresp_data_ok) begin
          pc_n    = redirect_valid ? redirect_pc : pend_pc;
          state_n = FETCH;
        end else if (redirect_valid) begin
          pend_pc_n = redirect_pc;
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;
  import pipes_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  fetch_data_t dataF;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .resetn(resetn), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dataF(dataF),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic ok, input logic [31:0] d, input logic st,
                       input logic rv, input logic [63:0] rpc);
    iresp_data_ok  = ok;
    iresp_data     = d;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_df(input string tag, input logic [31:0] ins, input logic [63:0] p,
                          input logic en);
    check(tag, {31'd0, dataF}, {31'd0, ins, p, en});
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0);
    // 1: reset
    repeat (3) step();
    check("rst_valid", ireq_valid, 1'b0);
    check("rst_en", dataF.en, 1'b0);
    check("rst_state", state_dbg, FETCH);
    resetn = 1'b1;
    step();
    check("rel_valid", ireq_valid, 1'b1);
    check("rel_addr", ireq_addr, 64'h8000_0000);

    // 2: streaming
    drive(1, 32'h0000_0013, 0, 0, 0);
    step();
    check_df("str0_df", 32'h13, 64'h8000_0000, 1);
    check("str0_addr", ireq_addr, 64'h8000_0004);
    drive(1, 32'h0010_0093, 0, 0, 0);
    step();
    check_df("str1_df", 32'h0010_0093, 64'h8000_0004, 1);
    check("str1_addr", ireq_addr, 64'h8000_0008);

    // 3: stall into HOLD
    drive(1, 32'h0000_ABCD, 1, 0, 0);
    step();
    check_df("hold0_df", 32'h0010_0093, 64'h8000_0004, 1);
    check("hold0_valid", ireq_valid, 1'b0);
    check("hold0_state", state_dbg, HOLD);
    drive(0, 0, 1, 0, 0);
    step();
    step();
    check_df("hold2_df", 32'h0010_0093, 64'h8000_0004, 1);
    check("hold2_valid", ireq_valid, 1'b0);
    drive(0, 0, 0, 0, 0);
    step();
    check_df("unhold_df", 32'h0000_ABCD, 64'h8000_0008, 1);
    check("unhold_addr", ireq_addr, 64'h8000_000C);
    check("unhold_valid", ireq_valid, 1'b1);
    drive(1, 32'h0000_0111, 0, 0, 0);
    step();
    check_df("f3_df", 32'h111, 64'h8000_000C, 1);

    // 4: redirect while outstanding
    drive(0, 0, 0, 1, 64'h8000_0100);
    step();
    check("disc0_en", dataF.en, 1'b0);
    check("disc0_addr", ireq_addr, 64'h8000_0010);
    check("disc0_state", state_dbg, DISCARD);
    drive(0, 0, 0, 0, 0);
    step();
    check("disc1_addr", ireq_addr, 64'h8000_0010);
    check("disc1_valid", ireq_valid, 1'b1);
    drive(1, 32'h0000_DEAD, 0, 0, 0);
    step();
    check("disc2_en", dataF.en, 1'b0);
    check("disc2_addr", ireq_addr, 64'h8000_0100);
    check("disc2_state", state_dbg, FETCH);

    // 5a: redirect together with data_ok
    drive(1, 32'h0000_0100, 0, 0, 0);
    step();
    check_df("r5_df", 32'h100, 64'h8000_0100, 1);
    drive(1, 32'h0000_0BAD, 0, 1, 64'h8000_0200);
    step();
    check("r5a_en", dataF.en, 1'b0);
    check("r5a_addr", ireq_addr, 64'h8000_0200);
    // 5b: redirect in HOLD with stall high
    drive(1, 32'h0000_0222, 0, 0, 0);
    step();
    check_df("r5b_df", 32'h222, 64'h8000_0200, 1);
    drive(1, 32'h0000_0333, 1, 0, 0);
    step();
    check("r5b_state", state_dbg, HOLD);
    drive(0, 0, 1, 1, 64'h8000_0300);
    step();
    check("r5b_en", dataF.en, 1'b0);
    check("r5b_addr", ireq_addr, 64'h8000_0300);
    check("r5b_state2", state_dbg, FETCH);

    // 6: wrap
    drive(1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("wrap0_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1, 32'h0000_0444, 0, 0, 0);
    step();
    check_df("wrap_df", 32'h444, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    check("wrap_addr", ireq_addr, 64'h0);

    // stall without data holds dataF; no data and no stall is a bubble
    drive(0, 0, 1, 0, 0);
    step();
    check_df("stall_nodata_df", 32'h444, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    drive(0, 0, 0, 0, 0);
    step();
    check("bubble_en", dataF.en, 1'b0);
    check("bubble_addr", ireq_addr, 64'h0);

    // DISCARD: latest redirect wins, same-cycle redirect beats pend_pc
    drive(0, 0, 0, 1, 64'h1000);
    step();
    drive(0, 0, 0, 1, 64'h2000);
    step();
    check("dd_addr", ireq_addr, 64'h0);
    drive(1, 32'h0000_0555, 0, 0, 0);
    step();
    check("dd_latest", ireq_addr, 64'h2000);
    drive(0, 0, 0, 1, 64'h3001);
    step();
    drive(1, 0, 0, 1, 64'h4000);
    step();
    check("dd_same", ireq_addr, 64'h4000);
    check("dd_en", dataF.en, 1'b0);

    // misaligned redirect issued as-is
    drive(1, 0, 0, 1, 64'h5003);
    step();
    check("misalign", ireq_addr, 64'h5003);

    // reset mid-request
    drive(0, 0, 0, 0, 0);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", ireq_valid, 1'b0);
    check("mid_rst_addr", ireq_addr, 64'h8000_0000);
    check("mid_rst_state", state_dbg, FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
